// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit and its memory-controller handshake.
// Holds the funct3 codes, the controller mode encodings, the response error codes and the FSM state type.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Encodings understood by memory_controller_module on instr_mode.
    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_BYTE = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_REQ  = 2'd1;
    localparam lsu_state_t ST_WAIT = 2'd2;
    localparam lsu_state_t ST_DONE = 2'd3;

    function automatic logic [1:0] mode_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return MODE_BYTE;
            2'b01:   return MODE_HALF;
            default: return MODE_WORD;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
        if (store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    endfunction

    // Only meaningful for legal funct3; byte accesses are never misaligned.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// Combinational load-data extension: the controller returns byte/half data zero-extended,
// this widens it to 32 bits according to the load's funct3.
module load_extender
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (funct3)
            F3_B:    data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    data = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   data = {24'h0, raw[7:0]};
            F3_HU:   data = {16'h0, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Core-side initiator for memory_controller_module: takes one load/store at a time,
// validates it, runs the enable/op_r handshake and returns a one-cycle response.
//
// Handshake: a request is taken on a rising edge where req_valid=1 and req_ready=1;
// req_ready is high only in IDLE and nothing is queued. resp_valid is a one-cycle
// strobe; resp_rdata/resp_err hold until the next response. mem_enable is a one-cycle
// start pulse and mem_op_r is only looked at while waiting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_mode,
    input  logic              mem_op_r,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t       state;
    logic [2:0]       funct3_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic [31:0]      ext_data;
    logic             req_legal;
    logic             req_misaligned;

    // Decoded from state so mem_enable and resp_valid drop the instant reset asserts.
    assign req_ready     = (state == ST_IDLE);
    assign mem_enable    = (state == ST_REQ);
    assign resp_valid    = (state == ST_DONE);
    assign dbg_state     = state;
    assign wait_cnt_next = wait_cnt + CNT_W'(1);

    assign req_legal      = funct3_legal(req_store, req_funct3);
    assign req_misaligned = misaligned(req_funct3, req_addr[1:0]);

    load_extender u_ext (
        .funct3 (funct3_q),
        .raw    (mem_rdata),
        .data   (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            funct3_q   <= 3'b000;
            wait_cnt   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            mem_mode   <= MODE_WORD;
            resp_rdata <= 32'h0;
            resp_err   <= ERR_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        mem_we    <= req_store;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        mem_mode  <= mode_of(req_funct3);
                        wait_cnt  <= '0;
                        // Illegal funct3 outranks misalignment; neither touches memory.
                        if (!req_legal) begin
                            state      <= ST_DONE;
                            resp_err   <= ERR_ILLEGAL;
                            resp_rdata <= 32'h0;
                        end else if (req_misaligned) begin
                            state      <= ST_DONE;
                            resp_err   <= ERR_MISALIGN;
                            resp_rdata <= 32'h0;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // op_r wins over the timeout when both land on the same edge.
                    if (mem_op_r) begin
                        state      <= ST_DONE;
                        resp_err   <= ERR_OK;
                        resp_rdata <= mem_we ? 32'h0 : ext_data;
                    end else if (wait_cnt_next == CNT_W'(TIMEOUT)) begin
                        state      <= ST_DONE;
                        resp_err   <= ERR_TIMEOUT;
                        resp_rdata <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
